// File: rtl/bool3_sweep_pkg.sv
// Shared types and sizes for the 3-input boolean truth-table sweep controller.
// Holds the controller state encoding and the vector/index/counter widths.
package bool3_sweep_pkg;

    localparam int unsigned NUM_VECTORS = 8;
    localparam int unsigned IDX_W       = 3;
    localparam int unsigned CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } state_e;

endpackage

// File: rtl/bool3_settle_timer.sv
// Settle timer: counts the cycles a vector has been held on the datapath.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   load_i      - clear the count to zero (new vector about to be held)
//   en_i        - count this cycle (controller is settling)
//   expire_c_o  - combinational: this is the last settle cycle of the vector
module bool3_settle_timer
    import bool3_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load_i,
    input  logic en_i,
    output logic expire_c_o
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Expiry in the cycle whose count is SETTLE_CYCLES-1, so the vector is held SETTLE_CYCLES cycles.
    assign expire_c_o = en_i && (cnt_q == CNT_W'(SETTLE_CYCLES - 1));

    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = '0;
        end else if (en_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/bool3_sweep_ctrl.sv
// Deterministic self-checking sweep of a 3-input boolean datapath.
// On start, drives {c,b,a} = 0..7, holds each vector SETTLE_CYCLES cycles, samples
// e_in into tt[idx], then compares tt against EXPECTED and reports pass/fail.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   start       - one-cycle sweep request, ignored unless idle
//   e_in        - datapath output e
//   a, b, c     - datapath inputs (vector index bits 0, 1, 2)
//   busy        - sweep in progress, including the done cycle
//   done        - one-cycle completion pulse
//   tt          - captured truth table, bit i = e for vector i
//   pass        - tt matched EXPECTED; held until the next accepted start
//   fail_idx    - first mismatching vector, meaningful only when pass=0
// Build option: define ABORT_ON_MISMATCH_EN to end the sweep at the first mismatch.
module bool3_sweep_ctrl
    import bool3_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2,
    parameter logic [7:0]  EXPECTED      = 8'hF8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic       e_in,
    output logic       a,
    output logic       b,
    output logic       c,
    output logic       busy,
    output logic       done,
    output logic [7:0] tt,
    output logic       pass,
    output logic [2:0] fail_idx
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VECTORS - 1);

    state_e                 state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic [NUM_VECTORS-1:0] tt_q, tt_d;
    logic                   pass_q, pass_d;
    logic [IDX_W-1:0]       fidx_q, fidx_d;
    logic                   mis_q, mis_d;
    logic                   mismatch;
    logic                   timer_load;
    logic                   timer_expire;

    bool3_settle_timer #(
        .SETTLE_CYCLES (SETTLE_CYCLES)
    ) u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (timer_load),
        .en_i       (state_q == SETTLE),
        .expire_c_o (timer_expire)
    );

    // Sweep sequencing, truth-table capture and first-mismatch tracking.
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        tt_d       = tt_q;
        pass_d     = pass_q;
        fidx_d     = fidx_q;
        mis_d      = mis_q;
        mismatch   = 1'b0;
        timer_load = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d      = '0;
                    busy_d     = 1'b1;
                    tt_d       = '0;
                    pass_d     = 1'b0;
                    fidx_d     = '0;
                    mis_d      = 1'b0;
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end

            SETTLE: begin
                if (timer_expire) begin
                    state_d = SAMPLE;
                end
            end

            SAMPLE: begin
                tt_d[idx_q] = e_in;
                mismatch    = (e_in != EXPECTED[idx_q]);
                if (mismatch && !mis_q) begin
                    fidx_d = idx_q;
                    mis_d  = 1'b1;
                end
`ifdef ABORT_ON_MISMATCH_EN
                if (mismatch) begin
                    pass_d  = 1'b0;
                    done_d  = 1'b1;
                    state_d = DONE;
                end else
`endif
                if (idx_q == LAST_IDX) begin
                    pass_d  = (tt_d == EXPECTED);
                    done_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    idx_d      = idx_q + IDX_W'(1);
                    timer_load = 1'b1;
                    state_d    = SETTLE;
                end
            end

            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tt_q    <= '0;
            pass_q  <= 1'b0;
            fidx_q  <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tt_q    <= tt_d;
            pass_q  <= pass_d;
            fidx_q  <= fidx_d;
            mis_q   <= mis_d;
        end
    end

    // Datapath inputs follow the registered vector index directly.
    assign a        = idx_q[0];
    assign b        = idx_q[1];
    assign c        = idx_q[2];
    assign busy     = busy_q;
    assign done     = done_q;
    assign tt       = tt_q;
    assign pass     = pass_q;
    assign fail_idx = fidx_q;

endmodule

// File: tb/tb_bool3_sweep_ctrl.sv
// Bench for bool3_sweep_ctrl: a truth-table "datapath" driven from the DUT's a/b/c,
// expected sweep results queued at each start, checked by a negedge monitor.
module tb_bool3_sweep_ctrl;

    localparam int         SETTLE = 2;
    localparam int         P      = SETTLE + 1;
    localparam logic [7:0] EXP    = 8'hF8;

    typedef struct {
        int         start_cyc;
        int         lat;
        logic [7:0] tt;
        logic       pass;
        logic [2:0] fi;
        logic [2:0] abc;
    } exp_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       e_in;
    logic       a, b, c;
    logic       busy, done, pass;
    logic [7:0] tt;
    logic [2:0] fail_idx;

    logic [7:0] func_r;
    int         cyc;
    int         n_tests;
    int         n_fail;
    int         to_cnt;
    int         to_seen;
    exp_t       q[$];
    logic [7:0] last_tt;
    logic       last_pass;
    logic [2:0] last_abc;

    bool3_sweep_ctrl #(
        .SETTLE_CYCLES (SETTLE),
        .EXPECTED      (EXP)
    ) u_dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .e_in     (e_in),
        .a        (a),
        .b        (b),
        .c        (c),
        .busy     (busy),
        .done     (done),
        .tt       (tt),
        .pass     (pass),
        .fail_idx (fail_idx)
    );

    // Combinational boolean block under test: a plain lookup of the selected table.
    assign e_in = func_r[{c, b, a}];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected result of one sweep, straight from the sweep rules.
    function automatic exp_t model(input logic [7:0] f, input int sc);
        exp_t e;
        bit   found;
        found       = 1'b0;
        e.start_cyc = sc;
        e.tt        = f;
        e.pass      = (f == EXP);
        e.fi        = 3'd0;
        e.lat       = 8 * P;
        e.abc       = 3'd7;
        for (int i = 0; i < 8; i++) begin
            if (!found && (f[i] != EXP[i])) begin
                found = 1'b1;
                e.fi  = 3'(i);
            end
        end
`ifdef ABORT_ON_MISMATCH_EN
        if (found) begin
            e.lat = (int'(e.fi) + 1) * P;
            e.abc = e.fi;
            for (int i = 0; i < 8; i++) begin
                if (i > int'(e.fi)) e.tt[i] = 1'b0;
            end
        end
`endif
        return e;
    endfunction

    task automatic chk(input string name, input int act, input int expv);
        n_tests++;
        if (act != expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: all checks happen here, away from the rising edge.
    always @(negedge clk) begin : mon
        exp_t e;
        int   k;
        bit   active;
        if (!rst_n) begin
            q.delete();
            last_tt   = 8'h00;
            last_pass = 1'b0;
            last_abc  = 3'd0;
            chk("reset_outputs", int'({a, b, c, busy, done, pass, tt, fail_idx}), 0);
        end else begin
            if (to_cnt != to_seen) begin
                chk("wait_timeout", to_cnt, to_seen);
                to_seen = to_cnt;
            end
            active = (q.size() != 0) && (cyc >= q[0].start_cyc);
            chk("busy", int'(busy), int'(active));
            if (done) begin
                chk("done_expected", int'(active), 1);
                if (active) begin
                    e = q.pop_front();
                    k = cyc - e.start_cyc;
                    chk("done_latency", k, e.lat);
                    chk("tt", int'(tt), int'(e.tt));
                    chk("pass", int'(pass), int'(e.pass));
                    if (!e.pass) chk("fail_idx", int'(fail_idx), int'(e.fi));
                    chk("abc_final", int'({c, b, a}), int'(e.abc));
                    last_tt   = e.tt;
                    last_pass = e.pass;
                    last_abc  = e.abc;
                end
            end else if (active) begin
                k = cyc - q[0].start_cyc;
                chk("done_missing", int'(k < q[0].lat), 1);
                chk("vector", int'({c, b, a}), k / P);
            end else begin
                chk("idle_hold", int'({c, b, a, pass, tt}), int'({last_abc, last_pass, last_tt}));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic step_to(input int target);
        int n;
        n = 0;
        while (cyc < target && n < 500) begin
            step();
            n++;
        end
    endtask

    task automatic launch(input logic [7:0] f, output int sc, output int lat);
        exp_t e;
        func_r = f;
        start  = 1'b1;
        e      = model(f, cyc + 1);
        q.push_back(e);
        sc     = e.start_cyc;
        lat    = e.lat;
        step();
        start  = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (q.size() != 0 && n < 300) begin
            step();
            n++;
        end
        if (q.size() != 0) to_cnt++;
    endtask

    initial begin : stim
        logic [7:0] fab;
        logic [7:0] f;
        int         sc;
        int         lat;
        n_tests   = 0;
        n_fail    = 0;
        to_cnt    = 0;
        to_seen   = 0;
        last_tt   = 8'h00;
        last_pass = 1'b0;
        last_abc  = 3'd0;
        rst_n     = 1'b0;
        start     = 1'b0;
        func_r    = 8'h00;
        for (int i = 0; i < 8; i++) begin
            logic [2:0] v;
            v      = 3'(i);
            fab[i] = (v[0] & v[1]) | v[2];
        end
        repeat (3) step();
        rst_n = 1'b1;
        repeat (2) step();

        // e = (a&b)|c: full pass
        launch(fab, sc, lat);
        wait_idle();
        // first vector differs: fail_idx 0
        launch(fab ^ 8'h01, sc, lat);
        wait_idle();
        // e stuck at 0: first mismatch at vector 3
        launch(8'h00, sc, lat);
        wait_idle();

        // Restarts while busy and during the done cycle are ignored; next idle cycle accepted.
        launch(fab, sc, lat);
        step_to(sc + 5);
        start = 1'b1;
        step();
        start = 1'b0;
        step_to(sc + 10);
        start = 1'b1;
        step();
        start = 1'b0;
        step_to(sc + lat);
        start = 1'b1;
        step();
        start = 1'b0;
        launch(8'($urandom), sc, lat);
        wait_idle();

        // Reset mid-sweep aborts with no done pulse.
        launch(fab, sc, lat);
        step_to(sc + 13);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        repeat (40) step();
        launch(fab, sc, lat);
        wait_idle();

        // Random tables and single-bit faults at random positions.
        for (int it = 0; it < 16; it++) begin
            if (it % 2 == 0) f = 8'($urandom);
            else             f = EXP ^ (8'd1 << $urandom_range(0, 7));
            repeat ($urandom_range(0, 3)) step();
            launch(f, sc, lat);
            wait_idle();
        end

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
